// File: rtl/knn_pkg.sv
// knn_ctrl shared definitions: state encoding, default latency, width helper.
// Optional stall support in knn_ctrl is enabled by KNN_CTRL_STALL_EN.
package knn_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_VOTE   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam int CALC_LAT_DEF = 3;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_CLEAR  = ST_CLEAR,
    S_STREAM = ST_STREAM,
    S_DRAIN  = ST_DRAIN,
    S_VOTE   = ST_VOTE,
    S_DONE   = ST_DONE
  } state_t;

  function automatic int idxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/knn_delay_line.sv
// Fixed-depth shift register, flushed by synchronous reset.
// Used to align strobes and addresses with the knn_unit pipeline.
module knn_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/knn_ctrl.sv
// Sequencer for one knn_unit: clear, stream dataset, drain, vote, done.
// Define KNN_CTRL_STALL_EN to add the dataReady stream-stall input.
module knn_ctrl
  import knn_pkg::*;
#(
  parameter int N_COORDS = 2,
  parameter int PTS_W    = 8,
  parameter int K        = 8,
  parameter int K_W      = 3,
  parameter int CALC_LAT = CALC_LAT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef KNN_CTRL_STALL_EN
  input  logic                        dataReady,
`endif
  input  logic                        start,
  input  logic [PTS_W-1:0]            nPoints,
  output logic                        busy,
  output logic                        done,
  output logic                        unitRst,
  output logic [PTS_W-1:0]            pointIndex,
  output logic [idxW(N_COORDS)-1:0]   coordIndex,
  output logic                        unitValid,
  output logic [PTS_W-1:0]            classPointIndex,
  output logic                        incrementClass,
  output logic [K_W-1:0]              classIndex
);

  localparam int CW = idxW(N_COORDS);
  localparam int DW = idxW(CALC_LAT + 2);
  localparam int VW = K_W + 1;

  state_t          state;
  logic [PTS_W-1:0] ptsReg;
  logic [VW-1:0]   voteN;
  logic [DW-1:0]   drainCnt;
  logic            go;
  logic            issue;

`ifdef KNN_CTRL_STALL_EN
  assign go = dataReady;
`else
  assign go = 1'b1;
`endif

  // An address only counts as issued when the stream advances past it.
  assign issue = (state == S_STREAM) & go;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ptsReg         <= '0;
      voteN          <= '0;
      drainCnt       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      unitRst        <= 1'b0;
      pointIndex     <= '0;
      coordIndex     <= '0;
      incrementClass <= 1'b0;
      classIndex     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            ptsReg  <= nPoints;
            if (nPoints >= PTS_W'(K)) voteN <= VW'(K);
            else                      voteN <= VW'(nPoints);
            unitRst <= 1'b1;
            busy    <= 1'b1;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          unitRst    <= 1'b0;
          pointIndex <= '0;
          coordIndex <= '0;
          if (ptsReg == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (go) begin
            if (coordIndex == CW'(N_COORDS - 1)) begin
              coordIndex <= '0;
              if (pointIndex == ptsReg - PTS_W'(1)) begin
                pointIndex <= '0;
                drainCnt   <= '0;
                state      <= S_DRAIN;
              end else begin
                pointIndex <= pointIndex + PTS_W'(1);
              end
            end else begin
              coordIndex <= coordIndex + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drainCnt == DW'(CALC_LAT + 1)) begin
            incrementClass <= 1'b1;
            classIndex     <= '0;
            state          <= S_VOTE;
          end else begin
            drainCnt <= drainCnt + DW'(1);
          end
        end
        S_VOTE: begin
          if ({1'b0, classIndex} == voteN - VW'(1)) begin
            incrementClass <= 1'b0;
            classIndex     <= '0;
            done           <= 1'b1;
            state          <= S_DONE;
          end else begin
            classIndex <= classIndex + K_W'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  knn_delay_line #(.DEPTH(1), .W(1)) uValidDly (
    .clk (clk),
    .rst (rst),
    .d   (issue),
    .q   (unitValid)
  );

  knn_delay_line #(.DEPTH(CALC_LAT + 1), .W(PTS_W)) uClassDly (
    .clk (clk),
    .rst (rst),
    .d   (pointIndex),
    .q   (classPointIndex)
  );

endmodule

// File: tb/tb_knn_ctrl.sv
// Directed bench for knn_ctrl (N_COORDS=2, K=8, CALC_LAT=3).
// Stall scenario runs only when KNN_CTRL_STALL_EN is defined.
module tb_knn_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] nPoints = '0;
  logic       busy, done, unitRst, unitValid, incrementClass;
  logic [7:0] pointIndex, classPointIndex;
  logic [0:0] coordIndex;
  logic [2:0] classIndex;
`ifdef KNN_CTRL_STALL_EN
  logic       dataReady = 1'b1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  knn_ctrl #(
    .N_COORDS (2),
    .PTS_W    (8),
    .K        (8),
    .K_W      (3),
    .CALC_LAT (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
`ifdef KNN_CTRL_STALL_EN
    .dataReady       (dataReady),
`endif
    .start           (start),
    .nPoints         (nPoints),
    .busy            (busy),
    .done            (done),
    .unitRst         (unitRst),
    .pointIndex      (pointIndex),
    .coordIndex      (coordIndex),
    .unitValid       (unitValid),
    .classPointIndex (classPointIndex),
    .incrementClass  (incrementClass),
    .classIndex      (classIndex)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int outsOr();
    return int'(busy) | int'(done) | int'(unitRst) | int'(unitValid) |
           int'(incrementClass) | int'(pointIndex) | int'(coordIndex) |
           int'(classPointIndex) | int'(classIndex);
  endfunction

  task automatic runOnce(input string tag, input int pts, input bit hold,
                         input bit stall, input int expDone);
    int cyc = 0, nv = 0, nVote = 0, nRst = 0, rstCyc = -1, busyN = 0;
    int addrErr = 0, voteErr = 0, cpErr = 0, held = 0;
    int firstV = -1, lastV = -1, doneCyc = -1, stallLeft = 0;
    int expV;
    bit seen = 0, stallDone = 0;
    int prevP, prevC;
    int hist [0:255];
    expV = (pts < 8) ? pts : 8;
    @(negedge clk);
    start = 1'b1;
    nPoints = 8'(pts);
    hist[0] = int'(pointIndex);
    while (!seen && cyc < 200) begin
      prevP = int'(pointIndex);
      prevC = int'(coordIndex);
      @(negedge clk);
      cyc++;
      if (!hold) start = 1'b0;
      nPoints = 8'hAA;
      hist[cyc] = int'(pointIndex);
      if (unitValid) begin
        if (prevP != nv / 2 || prevC != nv % 2) addrErr++;
        if (firstV < 0) firstV = cyc;
        lastV = cyc;
        nv++;
      end
      if (incrementClass) begin
        if (int'(classIndex) != nVote) voteErr++;
        nVote++;
      end
      if (unitRst) begin
        nRst++;
        rstCyc = cyc;
      end
      if (busy) busyN++;
      if (cyc >= 4 && int'(classPointIndex) != hist[cyc-4]) cpErr++;
      if (pointIndex == 8'd1 && coordIndex == 1'b0 && cyc >= 2) held++;
`ifdef KNN_CTRL_STALL_EN
      if (stall) begin
        if (!stallDone && pointIndex == 8'd1 && coordIndex == 1'b0) begin
          stallLeft = 3;
          stallDone = 1;
        end
        if (stallLeft > 0) begin
          dataReady = 1'b0;
          stallLeft--;
        end else begin
          dataReady = 1'b1;
        end
      end
`endif
      if (done) begin
        seen = 1;
        doneCyc = cyc;
        start = 1'b0;
      end
    end
    chk({tag, ".doneCyc"}, doneCyc, expDone);
    chk({tag, ".nValid"}, nv, 2 * pts);
    chk({tag, ".addrErr"}, addrErr, 0);
    chk({tag, ".nVote"}, nVote, expV);
    chk({tag, ".voteIdxErr"}, voteErr, 0);
    chk({tag, ".nUnitRst"}, nRst, 1);
    chk({tag, ".unitRstCyc"}, rstCyc, 1);
    chk({tag, ".busyCycles"}, busyN, expDone);
    chk({tag, ".classPtErr"}, cpErr, 0);
    if (pts >= 2) begin
      chk({tag, ".addrHold"}, held, stall ? 4 : 1);
      chk({tag, ".validGap"}, lastV - firstV + 1 - nv, stall ? 3 : 0);
    end
    @(negedge clk);
    chk({tag, ".idleOuts"}, outsOr(), 0);
    if (hold) begin
      busyN = 0;
      repeat (5) begin
        @(negedge clk);
        if (busy || done) busyN++;
      end
      chk({tag, ".noRerun"}, busyN, 0);
    end
  endtask

  initial begin
    int waitN;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset.outs", outsOr(), 0);

    runOnce("p4", 4, 0, 0, 19);
    runOnce("p20", 20, 0, 0, 55);
    runOnce("p0", 0, 0, 0, 2);
    runOnce("hold", 4, 1, 0, 19);

    @(negedge clk);
    start = 1'b1;
    nPoints = 8'd4;
    @(negedge clk);
    start = 1'b0;
    waitN = 0;
    while (pointIndex != 8'd2 && waitN < 50) begin
      @(negedge clk);
      waitN++;
    end
    chk("midrst.reached", int'(pointIndex), 2);
    chk("midrst.busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.outs", outsOr(), 0);
    runOnce("afterRst", 4, 0, 0, 19);

`ifdef KNN_CTRL_STALL_EN
    runOnce("stall", 4, 0, 1, 22);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/knn_ctrl.md
# knn_ctrl

Sequencer for a single `knn_unit`. On `start` it:
- clears the unit;
- streams every coordinate of every dataset point into the distance pipeline;
- waits for the ordered list to settle;
- issues the class-vote pulses, then flags `done`.

The block sits between the software-visible register bank and one `knn_unit` plus its dataset/class memories.

## Interface
Parameters:
- `N_COORDS`, 2: coordinates per point.
- `PTS_W`, 8: width of the point counter.
- `K`, 8: neighbours voted.
- `K_W`, 3: width of `classIndex`.
- `CALC_LAT`, 3: cycles from the last coordinate in to `outputValid` inside the unit.

Ports:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous active-high reset.
- `start`, in, 1: begin a classification (sampled in IDLE only).
- `nPoints`, in, PTS_W: dataset points for this run (latched at start).
- `busy`, out, 1: high from the cycle after start up to and including the DONE cycle.
- `done`, out, 1: one-cycle pulse; `classOut` is valid from this cycle.
- `unitRst`, out, 1: one-cycle clear pulse, ORed with `rst` at the unit.
- `pointIndex`, out, PTS_W: dataset memory point address.
- `coordIndex`, out, clog2(N_COORDS): dataset memory coordinate address.
- `unitValid`, out, 1: drives the unit's `valid`.
- `classPointIndex`, out, PTS_W: class memory address, aligned to the unit's `outputValid`.
- `incrementClass`, out, 1: vote strobe.
- `classIndex`, out, K_W: list slot being voted.

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, VOTE, DONE.
- IDLE: all outputs 0. `start`=1 does two things:
  - latches `nPoints` into `ptsReg` and sets `voteN` = min(nPoints, K);
  - moves to CLEAR.
- CLEAR, one cycle:
  - `unitRst`=1 and `busy`=1; indices are zeroed;
  - `ptsReg`==0 goes to DONE, otherwise to STREAM.
- STREAM:
  - each cycle presents address (`pointIndex`, `coordIndex`);
  - `coordIndex` counts 0..N_COORDS-1, then wraps to 0 and increments `pointIndex`;
  - after address (ptsReg-1, N_COORDS-1) the state goes to DRAIN.
- Dataset memory is synchronous read, so `unitValid` is the address-issue strobe delayed one register.
- `classPointIndex` is `pointIndex` delayed by CALC_LAT+1 cycles through a register chain.
  - This aligns the class read with the unit's `outputValid`, assuming a synchronous class read into `classIn`.
- DRAIN:
  - waits CALC_LAT+2 cycles so the final insert reaches the ordered list;
  - `unitValid` is 0 after its last delayed pulse.
- VOTE:
  - `incrementClass`=1 for exactly `voteN` consecutive cycles, with `classIndex` = 0, 1, …, voteN-1;
  - empty list slots are never voted.
- DONE, one cycle: `done`=1, `busy`=1, then back to IDLE.
- `start` while busy is ignored; `nPoints` changes after latch have no effect.
- `rst` in any state: next cycle is IDLE with all counters and outputs 0, and the delay chain is flushed.
  - `unitRst` is not pulsed, because the unit is already reset by `rst`.

## Timing
- Start accepted at cycle 0 gives this schedule:
  - CLEAR at cycle 1;
  - first address at cycle 2;
  - first `unitValid` at cycle 3.
- Run length, start to done inclusive: 1 + 1 + P·N_COORDS + (CALC_LAT+2) + voteN + 1 cycles, where P = nPoints.
  - P=0 gives start, then CLEAR, then DONE, so `done` at cycle 2.
- A new `start` is accepted in the cycle after DONE at the earliest.
- All outputs are registered, with no combinational path from `start` to outputs.

## Configuration
- Macro `KNN_CTRL_STALL_EN`.
- Defined:
  - adds input `dataReady` (1 bit);
  - in STREAM, `dataReady`=0 holds the address counters, and `unitValid` is 0 one cycle later;
  - DRAIN and VOTE are unaffected.
- Undefined: the port is absent and streaming never stalls.

## Structure
- Shared package `knn_pkg`:
  - state encoding localparams (IDLE=0 … DONE=5);
  - default CALC_LAT;
  - a clog2-based width helper used by `coordIndex`.
- One sub-module: `knn_delay_line`, a parameterised-depth, parameterised-width shift register.
  - It is used for the `unitValid` and `classPointIndex` alignment.

## Test plan
- nPoints=4, N_COORDS=2, K=8, CALC_LAT=3:
  - 8 `unitValid` pulses with addresses (0,0),(0,1),(1,0)…(3,1);
  - `voteN`=4, so `classIndex` 0..3;
  - `done` at cycle 2+8+5+4 = 19.
- nPoints=20, K=8: exactly 8 vote cycles (`classIndex` 0..7); `done` at cycle 2+40+5+8 = 55.
- nPoints=0: `unitRst` pulse at cycle 1, `done` at cycle 2, no `unitValid` and no `incrementClass`.
- `start` held high throughout a run, then dropped in the DONE cycle: exactly one run and one `done`.
- `rst` asserted mid-STREAM (point 2): next cycle IDLE, all outputs 0; a subsequent `start` begins again from point 0.
- With `KNN_CTRL_STALL_EN` defined, `dataReady` low for 3 cycles at address (1,0):
  - address holds for 3 cycles;
  - `unitValid` has a 3-cycle gap;
  - `done` is delayed by exactly 3 cycles.
